// File: rtl/parser_type_lookup.sv
`default_nettype none
// ============================================================================
// parser_type_lookup - masked type-rule lookup, lowest-index priority, 2-stage
// valid/ready pipeline. Optional hit/miss counters: PARSER_LOOKUP_CNT_EN.
// Revision: 1.0
// ============================================================================
module parser_type_lookup #(
    parameter int TYPE_NUM   = 2,
    parameter int TYPE_WIDTH = 8,
    parameter int RULE_NUM   = 8,
    parameter int RST_WIDTH  = 256,
    parameter int IDX_W      = $clog2(RULE_NUM + 1)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [TYPE_NUM*TYPE_WIDTH-1:0] i_type,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_hit,
    output logic [IDX_W-1:0]               o_rule_idx,
    output logic [RST_WIDTH-1:0]           o_rst,
    input  logic                           i_rule_wren,
    input  logic [IDX_W-1:0]               i_rule_idx,
    input  logic                           i_rule_valid,
    input  logic [TYPE_NUM*TYPE_WIDTH-1:0] i_rule_data,
    input  logic [TYPE_NUM*TYPE_WIDTH-1:0] i_rule_mask,
    input  logic [RST_WIDTH-1:0]           i_rule_rst,
    input  logic                           i_cnt_rden,
    input  logic [IDX_W-1:0]               i_cnt_idx,
    input  logic                           i_cnt_clr,
    output logic                           o_cnt_rvalid,
    output logic [31:0]                    o_cnt_data
);

    localparam int KEY_W = TYPE_NUM * TYPE_WIDTH;

    // ------------------------------------------------------------------
    // Rule table
    // ------------------------------------------------------------------
    logic                 rule_valid_q [RULE_NUM];
    logic                 rule_valid_d [RULE_NUM];
    logic [KEY_W-1:0]     rule_data_q  [RULE_NUM];
    logic [KEY_W-1:0]     rule_data_d  [RULE_NUM];
    logic [KEY_W-1:0]     rule_mask_q  [RULE_NUM];
    logic [KEY_W-1:0]     rule_mask_d  [RULE_NUM];
    logic [RST_WIDTH-1:0] rule_rst_q   [RULE_NUM];
    logic [RST_WIDTH-1:0] rule_rst_d   [RULE_NUM];

    // Out-of-range write indices never equal any r and are dropped here.
    always_comb begin
        for (int r = 0; r < RULE_NUM; r++) begin
            rule_valid_d[r] = rule_valid_q[r];
            rule_data_d[r]  = rule_data_q[r];
            rule_mask_d[r]  = rule_mask_q[r];
            rule_rst_d[r]   = rule_rst_q[r];
            if (i_rule_wren && (i_rule_idx == IDX_W'(r))) begin
                rule_valid_d[r] = i_rule_valid;
                rule_data_d[r]  = i_rule_data;
                rule_mask_d[r]  = i_rule_mask;
                rule_rst_d[r]   = i_rule_rst;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < RULE_NUM; r++) begin
                rule_valid_q[r] <= 1'b0;
                rule_data_q[r]  <= '0;
                rule_mask_q[r]  <= '0;
                rule_rst_q[r]   <= '0;
            end
        end else begin
            rule_valid_q <= rule_valid_d;
            rule_data_q  <= rule_data_d;
            rule_mask_q  <= rule_mask_d;
            rule_rst_q   <= rule_rst_d;
        end
    end

    // ------------------------------------------------------------------
    // Match and priority encode (descending scan so the lowest index wins)
    // ------------------------------------------------------------------
    logic                 lk_hit;
    logic [IDX_W-1:0]     lk_idx;
    logic [RST_WIDTH-1:0] lk_rst;

    always_comb begin
        lk_hit = 1'b0;
        lk_idx = IDX_W'(RULE_NUM);
        lk_rst = '0;
        for (int r = RULE_NUM - 1; r >= 0; r--) begin
            if (rule_valid_q[r] && (((i_type ^ rule_data_q[r]) & rule_mask_q[r]) == '0)) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(r);
                lk_rst = rule_rst_q[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Two-stage pipeline
    // ------------------------------------------------------------------
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_hit_q,   s1_hit_d;
    logic [IDX_W-1:0]     s1_idx_q,   s1_idx_d;
    logic [RST_WIDTH-1:0] s1_rst_q,   s1_rst_d;
    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_hit_q,   s2_hit_d;
    logic [IDX_W-1:0]     s2_idx_q,   s2_idx_d;
    logic [RST_WIDTH-1:0] s2_rst_q,   s2_rst_d;
    logic                 s2_adv;
    logic                 s1_adv;

    assign s2_adv  = !s2_valid_q || i_ready;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign o_ready = s1_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_hit_d   = s1_hit_q;
        s1_idx_d   = s1_idx_q;
        s1_rst_d   = s1_rst_q;
        s2_valid_d = s2_valid_q;
        s2_hit_d   = s2_hit_q;
        s2_idx_d   = s2_idx_q;
        s2_rst_d   = s2_rst_q;
        if (s1_adv) begin
            s1_valid_d = i_valid;
            if (i_valid) begin
                s1_hit_d = lk_hit;
                s1_idx_d = lk_idx;
                s1_rst_d = lk_rst;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_hit_d = s1_hit_q;
                s2_idx_d = s1_idx_q;
                s2_rst_d = s1_rst_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_idx_q   <= '0;
            s1_rst_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_hit_q   <= 1'b0;
            s2_idx_q   <= '0;
            s2_rst_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_hit_q   <= s1_hit_d;
            s1_idx_q   <= s1_idx_d;
            s1_rst_q   <= s1_rst_d;
            s2_valid_q <= s2_valid_d;
            s2_hit_q   <= s2_hit_d;
            s2_idx_q   <= s2_idx_d;
            s2_rst_q   <= s2_rst_d;
        end
    end

    assign o_valid    = s2_valid_q;
    assign o_hit      = s2_hit_q;
    assign o_rule_idx = s2_idx_q;
    assign o_rst      = s2_rst_q;

    // ------------------------------------------------------------------
    // Hit/miss counters; cnt_rd is the pre-update value of the read index
    // ------------------------------------------------------------------
    logic [31:0] cnt_rd;

`ifdef PARSER_LOOKUP_CNT_EN
    logic [31:0] cnt_q [RULE_NUM+1];
    logic [31:0] cnt_d [RULE_NUM+1];
    logic        out_hs;

    assign out_hs = s2_valid_q && i_ready;

    // Priority: clear-all over rule-write clear over increment.
    always_comb begin
        cnt_rd = '0;
        for (int c = 0; c <= RULE_NUM; c++) begin
            cnt_d[c] = cnt_q[c];
            if (out_hs && (s2_idx_q == IDX_W'(c)) && (cnt_q[c] != 32'hFFFF_FFFF)) begin
                cnt_d[c] = cnt_q[c] + 32'd1;
            end
            if (i_rule_wren && (c < RULE_NUM) && (i_rule_idx == IDX_W'(c))) begin
                cnt_d[c] = '0;
            end
            if (i_cnt_clr) begin
                cnt_d[c] = '0;
            end
            if (i_cnt_idx == IDX_W'(c)) begin
                cnt_rd = cnt_q[c];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c <= RULE_NUM; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cnt;

    assign cnt_rd     = '0;
    assign unused_cnt = ^{i_cnt_clr, i_cnt_idx};
`endif

    logic        cnt_rvalid_q, cnt_rvalid_d;
    logic [31:0] cnt_data_q,   cnt_data_d;

    always_comb begin
        cnt_rvalid_d = i_cnt_rden;
        cnt_data_d   = cnt_data_q;
        if (i_cnt_rden) begin
            cnt_data_d = cnt_rd;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_rvalid_q <= 1'b0;
            cnt_data_q   <= '0;
        end else begin
            cnt_rvalid_q <= cnt_rvalid_d;
            cnt_data_q   <= cnt_data_d;
        end
    end

    assign o_cnt_rvalid = cnt_rvalid_q;
    assign o_cnt_data   = cnt_data_q;

endmodule
`default_nettype wire

// File: tb/tb_parser_type_lookup.sv
`default_nettype none
// ============================================================================
// tb_parser_type_lookup - directed vectors, corner sequences and random
// traffic against a queue-based reference model of parser_type_lookup.
// Revision: 1.0
// ============================================================================
module tb_parser_type_lookup;

    localparam int TN = 2;
    localparam int TW = 16;
    localparam int KW = TN * TW;
    localparam int RN = 8;
    localparam int RW = 256;
    localparam int IW = $clog2(RN + 1);
`ifdef PARSER_LOOKUP_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [KW-1:0] i_type;
    logic          o_valid;
    logic          i_ready;
    logic          o_hit;
    logic [IW-1:0] o_rule_idx;
    logic [RW-1:0] o_rst;
    logic          i_rule_wren;
    logic [IW-1:0] i_rule_idx;
    logic          i_rule_valid;
    logic [KW-1:0] i_rule_data;
    logic [KW-1:0] i_rule_mask;
    logic [RW-1:0] i_rule_rst;
    logic          i_cnt_rden;
    logic [IW-1:0] i_cnt_idx;
    logic          i_cnt_clr;
    logic          o_cnt_rvalid;
    logic [31:0]   o_cnt_data;

    parser_type_lookup #(
        .TYPE_NUM(TN), .TYPE_WIDTH(TW), .RULE_NUM(RN), .RST_WIDTH(RW)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_type(i_type), .o_valid(o_valid), .i_ready(i_ready), .o_hit(o_hit),
        .o_rule_idx(o_rule_idx), .o_rst(o_rst), .i_rule_wren(i_rule_wren),
        .i_rule_idx(i_rule_idx), .i_rule_valid(i_rule_valid), .i_rule_data(i_rule_data),
        .i_rule_mask(i_rule_mask), .i_rule_rst(i_rule_rst), .i_cnt_rden(i_cnt_rden),
        .i_cnt_idx(i_cnt_idx), .i_cnt_clr(i_cnt_clr), .o_cnt_rvalid(o_cnt_rvalid),
        .o_cnt_data(o_cnt_data)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit            hit;
        int            idx;
        logic [RW-1:0] p;
        int            vis;   // first cycle the result may be on the output
    } sb_t;

    bit            m_valid [RN];
    logic [KW-1:0] m_data  [RN];
    logic [KW-1:0] m_mask  [RN];
    logic [RW-1:0] m_rst   [RN];
    logic [31:0]   m_cnt   [RN+1];
    sb_t           sb[$];
    bit            rd_pend;
    logic [31:0]   rd_exp;
    int            cyc;
    int            n_tests;
    int            n_fail;
    int            n_dut_out;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_wipe();
        for (int r = 0; r < RN; r++) begin
            m_valid[r] = 1'b0; m_data[r] = '0; m_mask[r] = '0; m_rst[r] = '0;
        end
        for (int c = 0; c <= RN; c++) m_cnt[c] = '0;
        sb.delete();
        rd_pend = 1'b0;
        rd_exp  = '0;
    endtask

    function automatic void ref_lookup(input logic [KW-1:0] t, output bit h,
                                       output int idx, output logic [RW-1:0] p);
        h = 1'b0; idx = RN; p = '0;
        for (int r = 0; r < RN; r++) begin
            if (m_valid[r] && (((t ^ m_data[r]) & m_mask[r]) == '0)) begin
                h = 1'b1; idx = r; p = m_rst[r];
                break;
            end
        end
    endfunction

    // One clock cycle: check outputs mid-cycle, advance the model, return at posedge+1.
    task automatic cycle();
        bit  ev, er, hs, acc;
        sb_t e;
        int  ci;
        @(negedge i_clk);
        ev = (sb.size() > 0) && (sb[0].vis <= cyc);
        er = !((sb.size() == 2) && !i_ready);
        chk("o_valid", o_valid, ev);
        chk("o_ready", o_ready, er);
        if (ev) begin
            chk("o_hit", o_hit, sb[0].hit);
            chk("o_rule_idx", o_rule_idx, sb[0].idx);
            chk("o_rst", o_rst, sb[0].p);
        end
        chk("o_cnt_rvalid", o_cnt_rvalid, rd_pend);
        if (rd_pend) chk("o_cnt_data", o_cnt_data, rd_exp);
        if (o_valid && i_ready) n_dut_out++;

        rd_pend = i_cnt_rden;
        rd_exp  = '0;
        if (CNT_ON && (int'(i_cnt_idx) <= RN)) rd_exp = m_cnt[i_cnt_idx];

        hs  = ev && i_ready;
        acc = i_valid && er;
        if (hs) begin
            ci = sb[0].idx;
            if (m_cnt[ci] != 32'hFFFF_FFFF) m_cnt[ci] = m_cnt[ci] + 1;
            void'(sb.pop_front());
            if ((sb.size() > 0) && (sb[0].vis < cyc + 1)) sb[0].vis = cyc + 1;
        end
        if (acc) begin
            ref_lookup(i_type, e.hit, e.idx, e.p);
            e.vis = cyc + 2;
            sb.push_back(e);
        end
        if (i_rule_wren && (int'(i_rule_idx) < RN)) begin
            m_valid[i_rule_idx] = i_rule_valid;
            m_data[i_rule_idx]  = i_rule_data;
            m_mask[i_rule_idx]  = i_rule_mask;
            m_rst[i_rule_idx]   = i_rule_rst;
            m_cnt[i_rule_idx]   = '0;
        end
        if (i_cnt_clr) for (int c = 0; c <= RN; c++) m_cnt[c] = '0;
        cyc++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr_rule(input int idx, input bit v, input logic [KW-1:0] d,
                           input logic [KW-1:0] m, input logic [RW-1:0] p);
        i_rule_wren = 1'b1; i_rule_idx = IW'(idx); i_rule_valid = v;
        i_rule_data = d; i_rule_mask = m; i_rule_rst = p;
        cycle();
        i_rule_wren = 1'b0;
    endtask

    task automatic cnt_read(input int idx, input logic [31:0] exp, input string name);
        i_cnt_rden = 1'b1; i_cnt_idx = IW'(idx);
        cycle();
        i_cnt_rden = 1'b0;
        chk({name, "_rvalid"}, o_cnt_rvalid, 1'b1);
        chk(name, o_cnt_data, exp);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int            widx;
        bit            wv;
        logic [KW-1:0] wd;
        logic [KW-1:0] wm;
        logic [RW-1:0] wrst;
        logic [KW-1:0] typ;
        bit            ehit;
        int            eidx;
        logic [RW-1:0] erst;
    } vec_t;

    vec_t vecs[8];

    localparam logic [KW-1:0] ONES = 32'hFFFF_FFFF;

    initial begin
        logic [KW-1:0] pool [4];
        logic [KW-1:0] mpool [4];
        int            n0;

        vecs[0] = '{3, 1'b1, 32'h0800_0006, ONES,          256'hA5, 32'h0800_0006, 1'b1, 3,  256'hA5};
        vecs[1] = '{1, 1'b1, 32'h0800_0000, 32'hFF00_0000, 256'h11, 32'h0800_0011, 1'b1, 1,  256'h11};
        vecs[2] = '{5, 1'b1, 32'h0800_0011, ONES,          256'h55, 32'h0800_0011, 1'b1, 1,  256'h11};
        vecs[3] = '{1, 1'b0, 32'h0800_0000, 32'hFF00_0000, 256'h11, 32'h0800_0011, 1'b1, 5,  256'h55};
        vecs[4] = '{9, 1'b1, 32'h86DD_0000, 32'h0,         256'h99, 32'h86DD_0000, 1'b0, RN, 256'h0};
        vecs[5] = '{7, 1'b1, 32'h0,         32'h0,         256'h77, 32'h86DD_0000, 1'b1, 7,  256'h77};
        vecs[6] = '{6, 1'b1, 32'h0800_0000, 32'hFFFF_0000, 256'h66, 32'h0800_0006, 1'b1, 3,  256'hA5};
        vecs[7] = '{7, 1'b0, 32'h0,         32'h0,         256'h77, 32'h1234_5678, 1'b0, RN, 256'h0};

        pool[0] = 32'h0800_0006; pool[1] = 32'h0800_0011; pool[2] = 32'h86DD_0000; pool[3] = 32'h2222_0000;
        mpool[0] = ONES; mpool[1] = 32'hFF00_0000; mpool[2] = 32'h0; mpool[3] = 32'h0000_FFFF;

        n_tests = 0; n_fail = 0; n_dut_out = 0; cyc = 0;
        i_rst_n = 1'b0; i_valid = 1'b0; i_type = '0; i_ready = 1'b1;
        i_rule_wren = 1'b0; i_rule_idx = '0; i_rule_valid = 1'b0; i_rule_data = '0;
        i_rule_mask = '0; i_rule_rst = '0; i_cnt_rden = 1'b0; i_cnt_idx = '0; i_cnt_clr = 1'b0;
        model_wipe();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // reset state
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_ready", o_ready, 1'b1);
        chk("rst_o_hit", o_hit, 1'b0);
        chk("rst_o_rule_idx", o_rule_idx, 0);
        chk("rst_o_rst", o_rst, 0);
        chk("rst_o_cnt_rvalid", o_cnt_rvalid, 1'b0);
        chk("rst_o_cnt_data", o_cnt_data, 0);

        // table-driven: write, lookup, result exactly two cycles after accept
        for (int i = 0; i < 8; i++) begin
            wr_rule(vecs[i].widx, vecs[i].wv, vecs[i].wd, vecs[i].wm, vecs[i].wrst);
            i_valid = 1'b1; i_type = vecs[i].typ;
            cycle();
            i_valid = 1'b0;
            cycle();
            chk($sformatf("v%0d_valid", i), o_valid, 1'b1);
            chk($sformatf("v%0d_hit", i), o_hit, vecs[i].ehit);
            chk($sformatf("v%0d_idx", i), o_rule_idx, vecs[i].eidx);
            chk($sformatf("v%0d_rst", i), o_rst, vecs[i].erst);
            cycle();
        end

        // backpressure: two buffered, third stalls, then drain in order
        i_ready = 1'b0; i_valid = 1'b1;
        i_type = 32'h0800_0006; cycle();
        i_type = 32'h0800_0011; cycle();
        i_type = 32'h86DD_0000;
        chk("bp_ready_low", o_ready, 1'b0);
        repeat (3) cycle();
        chk("bp_head_rst", o_rst, 256'hA5);
        n0 = n_dut_out;
        i_ready = 1'b1;
        cycle();
        i_valid = 1'b0;
        repeat (4) cycle();
        chk("bp_out_count", n_dut_out - n0, 3);

        // write/lookup collision on rule 0
        i_rule_wren = 1'b1; i_rule_idx = '0; i_rule_valid = 1'b1;
        i_rule_data = 32'hCAFE_0000; i_rule_mask = ONES; i_rule_rst = 256'hC0;
        i_valid = 1'b1; i_type = 32'hCAFE_0000;
        cycle();
        i_rule_wren = 1'b0;
        cycle();
        i_valid = 1'b0;
        chk("col_first_hit", o_hit, 1'b0);
        chk("col_first_idx", o_rule_idx, RN);
        cycle();
        chk("col_second_hit", o_hit, 1'b1);
        chk("col_second_idx", o_rule_idx, 0);
        chk("col_second_rst", o_rst, 256'hC0);
        cycle();

        // counters: 4 hits on rule 2, 1 miss
        i_cnt_clr = 1'b1; cycle(); i_cnt_clr = 1'b0;
        wr_rule(2, 1'b1, 32'h2222_0000, ONES, 256'h22);
        i_valid = 1'b1; i_type = 32'h2222_0000;
        repeat (4) cycle();
        i_type = 32'h9999_9999; cycle();
        i_valid = 1'b0;
        repeat (4) cycle();
        cnt_read(2, CNT_ON ? 32'd4 : 32'd0, "cnt_rule2");
        cnt_read(RN, CNT_ON ? 32'd1 : 32'd0, "cnt_miss");
        cnt_read(12, 32'd0, "cnt_out_of_range");
        i_valid = 1'b1; i_type = 32'h2222_0000; cycle();
        i_valid = 1'b0; cycle();
        chk("clr_hs_valid", o_valid, 1'b1);
        i_cnt_clr = 1'b1; cycle(); i_cnt_clr = 1'b0;
        cnt_read(2, 32'd0, "cnt_after_clr");

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            i_valid = ($urandom % 3) != 0;
            i_ready = ($urandom % 4) != 0;
            i_type = pool[$urandom % 4] ^ (($urandom % 4 == 0) ? KW'($urandom % 256) : KW'(0));
            i_rule_wren = ($urandom % 6) == 0;
            i_rule_idx = IW'($urandom_range(0, 9));
            i_rule_valid = ($urandom % 4) != 0;
            i_rule_data = pool[$urandom % 4];
            i_rule_mask = mpool[$urandom % 4];
            i_rule_rst = {8{$urandom}};
            i_cnt_rden = ($urandom % 4) == 0;
            i_cnt_idx = IW'($urandom_range(0, 10));
            i_cnt_clr = ($urandom % 30) == 0;
            cycle();
        end
        i_valid = 1'b0; i_ready = 1'b1; i_rule_wren = 1'b0; i_cnt_rden = 1'b0; i_cnt_clr = 1'b0;
        repeat (4) cycle();

        // async reset with both stages full
        wr_rule(2, 1'b1, 32'h2222_0000, ONES, 256'h22);
        i_ready = 1'b0; i_valid = 1'b1; i_type = 32'h2222_0000;
        cycle(); cycle();
        i_valid = 1'b0;
        chk("ar_full_valid", o_valid, 1'b1);
        #3 i_rst_n = 1'b0;
        #1;
        chk("ar_o_valid", o_valid, 1'b0);
        chk("ar_o_ready", o_ready, 1'b1);
        model_wipe();
        i_ready = 1'b1;
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        i_valid = 1'b1; i_type = 32'h2222_0000; cycle();
        i_valid = 1'b0; cycle();
        chk("ar_after_valid", o_valid, 1'b1);
        chk("ar_after_hit", o_hit, 1'b0);
        chk("ar_after_idx", o_rule_idx, RN);
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
